sat_integrator: RTL and testbench

- Parametrised, pipelined saturating integrator for error-term conditioning ahead of the PID/motor-drive math.
- Clamps each incoming error sample to OUT_W bits, signed or unsigned, then accumulates into a saturating OUT_W accumulator.
- Provides anti-windup freeze, synchronous clear, per-sample clamp flags, a sticky overflow flag and a saturating event counter.
- Feeds the integral term; status outputs go to the debug/telemetry registers.

---
 rtl/sat_integrator.sv | 153 +++++++++++++++
 tb/tb_sat_integrator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sat_integrator.sv
// Two-stage saturating integrator: clamps each error sample to OUT_W bits, then
// accumulates into a saturating OUT_W accumulator with freeze, clear and clamp telemetry.
module sat_integrator #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [IN_W-1:0]  in_data,
  input  logic             signed_mode,
  input  logic             clr,
  input  logic             freeze,
  input  logic             clr_sticky,
  output logic             out_vld,
  output logic [OUT_W-1:0] out_data,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam logic [OUT_W-1:0] U_MAX = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // ---------------------------------------------------------------- stage 1
  logic [OUT_W-1:0] c1_data;
  logic             c1_hi, c1_lo;
  logic             ext_all0, ext_all1, upper_any;

  // In signed mode the sample fits when every bit from OUT_W-1 upward equals the sign.
  assign ext_all0  = ~|in_data[IN_W-1:OUT_W-1];
  assign ext_all1  =  &in_data[IN_W-1:OUT_W-1];
  assign upper_any =  |in_data[IN_W-1:OUT_W];

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    c1_data = in_data[OUT_W-1:0];
    c1_hi   = 1'b0;
    c1_lo   = 1'b0;
    if (signed_mode) begin
      if (in_data[IN_W-1] && !ext_all1) begin
        c1_data = S_MIN;
        c1_lo   = 1'b1;
      end else if (!in_data[IN_W-1] && !ext_all0) begin
        c1_data = S_MAX;
        c1_hi   = 1'b1;
      end
    end else if (upper_any) begin
      c1_data = U_MAX;
      c1_hi   = 1'b1;
    end
  end

  logic             s1_vld;
  logic [OUT_W-1:0] s1_data;
  logic             s1_signed, s1_hi, s1_lo;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_data   <= '0;
      s1_signed <= 1'b0;
      s1_hi     <= 1'b0;
      s1_lo     <= 1'b0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_data   <= c1_data;
        s1_signed <= signed_mode;
        s1_hi     <= c1_hi;
        s1_lo     <= c1_lo;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [OUT_W-1:0] acc;
  logic [OUT_W:0]   ext_acc, ext_s1, sum;
  logic [OUT_W-1:0] c2_data;
  logic             c2_hi, c2_lo;
  logic             hi_nxt, lo_nxt, clamp_evt;

  assign ext_acc = s1_signed ? {acc[OUT_W-1], acc} : {1'b0, acc};
  assign ext_s1  = s1_signed ? {s1_data[OUT_W-1], s1_data} : {1'b0, s1_data};
  assign sum     = ext_acc + ext_s1;

  always_comb begin
    c2_data = sum[OUT_W-1:0];
    c2_hi   = 1'b0;
    c2_lo   = 1'b0;
    if (s1_signed) begin
      if (sum[OUT_W] != sum[OUT_W-1]) begin
        c2_data = sum[OUT_W] ? S_MIN : S_MAX;
        c2_lo   = sum[OUT_W];
        c2_hi   = ~sum[OUT_W];
      end
    end else if (sum[OUT_W]) begin
      c2_data = U_MAX;
      c2_hi   = 1'b1;
    end
  end

  // The accumulator limit wins over the input clamp, so the two flags stay exclusive.
  assign hi_nxt    = c2_hi | (s1_hi & ~c2_lo);
  assign lo_nxt    = c2_lo | (s1_lo & ~c2_hi);
  assign clamp_evt = s1_vld & ~clr & ~freeze & (hi_nxt | lo_nxt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      out_vld <= 1'b0;
      sat_hi  <= 1'b0;
      sat_lo  <= 1'b0;
    end else begin
      out_vld <= s1_vld;
      sat_hi  <= 1'b0;
      sat_lo  <= 1'b0;
      if (clr) begin
        acc <= '0;
      end else if (s1_vld && !freeze) begin
        acc    <= c2_data;
        sat_hi <= hi_nxt;
        sat_lo <= lo_nxt;
      end
    end
  end

  // The accumulator register is the output; freeze and clear act on both at once.
  assign out_data = acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt    <= '0;
      sticky_ovf <= 1'b0;
    end else begin
      if (clamp_evt && (sat_cnt != {CNT_W{1'b1}})) begin
        sat_cnt <= sat_cnt + 1'b1;
      end
      if (clamp_evt) begin
        sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
        sticky_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sat_integrator.sv
// Scoreboard bench for sat_integrator: a behavioural integer model queues the
// expected output of every stimulus cycle, compared two cycles later.
module tb_sat_integrator;

  localparam int IN_W  = 16;
  localparam int OUT_W = 10;
  localparam int CNT_W = 2;

  localparam int S_MAX   = (1 << (OUT_W - 1)) - 1;
  localparam int S_MIN   = -(1 << (OUT_W - 1));
  localparam int U_MAX   = (1 << OUT_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_vld = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             signed_mode = 1'b0;
  logic             clr = 1'b0;
  logic             freeze = 1'b0;
  logic             clr_sticky = 1'b0;
  logic             out_vld;
  logic [OUT_W-1:0] out_data;
  logic             sat_hi, sat_lo, sticky_ovf;
  logic [CNT_W-1:0] sat_cnt;

  sat_integrator #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data),
    .signed_mode(signed_mode), .clr(clr), .freeze(freeze), .clr_sticky(clr_sticky),
    .out_vld(out_vld), .out_data(out_data), .sat_hi(sat_hi), .sat_lo(sat_lo),
    .sticky_ovf(sticky_ovf), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               vld;
    logic [OUT_W-1:0] data;
    bit               hi, lo;
    int               cnt;
    bit               sticky;
    bit               frz, clr, cs;
  } exp_t;

  exp_t sb[$];
  int   m_acc, m_cnt;
  bit   m_sticky;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void clamp(input int x, input bit sm, output int y, output bit hi, output bit lo);
    y = x; hi = 1'b0; lo = 1'b0;
    if (sm) begin
      if (x > S_MAX) begin y = S_MAX; hi = 1'b1; end
      else if (x < S_MIN) begin y = S_MIN; lo = 1'b1; end
    end else if (x > U_MAX) begin
      y = U_MAX; hi = 1'b1;
    end
  endfunction

  // One stimulus cycle: check the entry issued two cycles ago, drive this entry's
  // sample and the previous entry's stage-2 controls, then queue this entry's result.
  task automatic step(input bit vld, input logic [IN_W-1:0] d, input bit sm,
                      input bit frz, input bit c, input bit cs);
    exp_t e, o;
    int   x, y1, y2;
    bit   h1, l1, h2, l2, evt;
    @(negedge clk);
    if (sb.size() == 2) begin
      o = sb.pop_front();
      check("out_vld", 32'(out_vld), 32'(o.vld));
      check("out_data", 32'(out_data), 32'(o.data));
      check("sat_hi", 32'(sat_hi), 32'(o.hi));
      check("sat_lo", 32'(sat_lo), 32'(o.lo));
      check("sat_cnt", 32'(sat_cnt), 32'(o.cnt));
      check("sticky_ovf", 32'(sticky_ovf), 32'(o.sticky));
    end
    in_vld      = vld;
    in_data     = d;
    signed_mode = sm;
    if (sb.size() > 0) begin
      freeze = sb[$].frz; clr = sb[$].clr; clr_sticky = sb[$].cs;
    end else begin
      freeze = 1'b0; clr = 1'b0; clr_sticky = 1'b0;
    end

    e.vld = vld; e.hi = 1'b0; e.lo = 1'b0; e.frz = frz; e.clr = c; e.cs = cs;
    evt = 1'b0;
    if (c) begin
      m_acc = 0;
    end else if (vld && !frz) begin
      if (sm) x = int'($signed(d));
      else    x = int'(d);
      clamp(x, sm, y1, h1, l1);
      clamp(m_acc + y1, sm, y2, h2, l2);
      m_acc = y2;
      e.hi  = h2 | (h1 & !l2);
      e.lo  = l2 | (l1 & !h2);
      evt   = e.hi | e.lo;
    end
    if (evt) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      m_sticky = 1'b1;
    end else if (cs) begin
      m_sticky = 1'b0;
    end
    e.data   = m_acc[OUT_W-1:0];
    e.cnt    = m_cnt;
    e.sticky = m_sticky;
    sb.push_back(e);
  endtask

  task automatic flush();
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_vld = 1'b1; in_data = 16'h7FFF; signed_mode = 1'b1;
    clr = 1'b0; freeze = 1'b0; clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_vld", 32'(out_vld), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst sat_hi", 32'(sat_hi), 32'd0);
    check("rst sat_lo", 32'(sat_lo), 32'd0);
    check("rst sticky", 32'(sticky_ovf), 32'd0);
    check("rst sat_cnt", 32'(sat_cnt), 32'd0);
    rst_n = 1'b1; in_vld = 1'b0; in_data = '0;
    sb.delete();
    m_acc = 0; m_cnt = 0; m_sticky = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post-rst out_vld", 32'(out_vld), 32'd0);
    end
  endtask

  initial begin
    // Reset with a saturating sample held on the input.
    do_reset();

    // Unsigned input clamp, then accumulator clamp at the top.
    step(1, 16'h0400, 0, 0, 0, 0);
    step(1, 16'h0001, 0, 0, 0, 0);
    flush();

    // Signed negative input clamp, then recovery.
    do_reset();
    step(1, 16'h8000, 1, 0, 0, 0);
    step(1, 16'h0005, 1, 0, 0, 0);
    flush();

    // Signed accumulator clamp and a back-to-back run down to the negative limit.
    do_reset();
    step(1, 16'h01F4, 1, 0, 0, 0);
    step(1, 16'h0014, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 16'hFE70, 1, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    step(1, 16'h0003, 1, 0, 0, 0);
    flush();

    // Freeze and clear.
    do_reset();
    step(1, 16'h0050, 1, 0, 0, 0);
    step(1, 16'h0010, 1, 1, 0, 0);
    step(1, 16'h7FFF, 1, 1, 0, 0);
    step(1, 16'h0033, 1, 1, 1, 0);
    step(1, 16'h0007, 1, 0, 0, 0);
    step(0, '0, 1, 0, 1, 0);
    step(1, 16'hFFFB, 1, 0, 0, 0);
    flush();

    // Counter saturation and sticky flag set/clear priority.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 16'hFFFF, 0, 0, 0, 0);
    step(1, 16'hFFFF, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 1);
    step(1, 16'h0001, 0, 0, 1, 0);
    step(1, 16'h0002, 0, 0, 0, 0);
    flush();

    // Random signed traffic with occasional freeze, clear and sticky clear.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [IN_W-1:0] d;
      if ($urandom_range(0, 3) == 0) d = IN_W'($urandom());
      else d = IN_W'($signed($urandom_range(0, 800)) - 400);
      step($urandom_range(0, 4) != 0, d, 1,
           $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 7) == 0);
    end
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
